// File: rtl/tc_timer_pkg.sv
// Shared definitions for the 64-bit compare timer: FSM states, register map
// and ctrl/status bit positions.
package tc_timer_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PENDING  = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_CMP_LO  = 3'd0;
  localparam logic [2:0] ADDR_CMP_HI  = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_TIME_LO = 3'd4;
  localparam logic [2:0] ADDR_TIME_HI = 3'd5;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_MISSED   = 2;

endpackage

// File: rtl/tc_timer_cmp.sv
// Compare timer: raises a level interrupt when the upstream 64-bit time reaches
// a programmable compare value, with optional periodic reload and miss detection.
module tc_timer_cmp
  import tc_timer_pkg::*;
#(
  parameter int unsigned UUID = 0,
  parameter              NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] time_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        irq,
  input  logic        irq_ack
);

  // Identification only; no hardware depends on these.
  logic unused_params;
  assign unused_params = (UUID != 0) || (NAME != "");

  state_e      state_q, state_d;
  logic [63:0] cmp_q;
  logic [31:0] shadow_q, period_q, time_hi_q;
  logic        enable_q, periodic_q, missed_q;

  logic ctrl_wr, cmp_hi_wr, periodic_active, hit;
  logic reload, set_missed, clr_enable;
  logic [31:0] rd_mux;

  assign ctrl_wr         = wr_en && (wr_addr == ADDR_CTRL);
  assign cmp_hi_wr       = wr_en && (wr_addr == ADDR_CMP_HI);
  assign periodic_active = periodic_q && (period_q != 32'd0);
  assign hit             = (time_in >= cmp_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_DISARMED;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    reload     = 1'b0;
    set_missed = 1'b0;
    clr_enable = 1'b0;
    if (ctrl_wr) begin
      // A ctrl write owns the state for this edge, overriding ack and compare.
      if (!wr_data[CTRL_ENABLE])          state_d = ST_DISARMED;
      else if (state_q == ST_DISARMED)    state_d = ST_ARMED;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (hit) begin
            state_d = ST_PENDING;
            reload  = periodic_active;
          end
        end
        ST_PENDING: begin
          if (irq_ack) begin
            if (periodic_active) begin
              state_d = ST_ARMED;
            end else begin
              state_d    = ST_DISARMED;
              clr_enable = 1'b1;
            end
          end else if (periodic_active && hit) begin
            reload     = 1'b1;
            set_missed = 1'b1;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q      <= '1;
      shadow_q   <= '0;
      period_q   <= '0;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      missed_q   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= (state_d == ST_PENDING);

      if (wr_en && wr_addr == ADDR_CMP_LO) shadow_q <= wr_data;
      if (wr_en && wr_addr == ADDR_PERIOD) period_q <= wr_data;

      // A software commit beats a hardware reload landing on the same edge.
      if (cmp_hi_wr)   cmp_q <= {wr_data, shadow_q};
      else if (reload) cmp_q <= cmp_q + {32'd0, period_q};

      if (ctrl_wr) begin
        enable_q   <= wr_data[CTRL_ENABLE];
        periodic_q <= wr_data[CTRL_PERIODIC];
      end else if (clr_enable) begin
        enable_q   <= 1'b0;
      end

      if (ctrl_wr)         missed_q <= 1'b0;
      else if (set_missed) missed_q <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (rd_addr)
      ADDR_CMP_LO:  rd_mux = cmp_q[31:0];
      ADDR_CMP_HI:  rd_mux = cmp_q[63:32];
      ADDR_CTRL:    rd_mux = {27'd0, state_q, missed_q, periodic_q, enable_q};
      ADDR_PERIOD:  rd_mux = period_q;
      ADDR_TIME_LO: rd_mux = time_in[31:0];
      ADDR_TIME_HI: rd_mux = time_hi_q;
      default:      rd_mux = '0;
    endcase
  end

  // The hi half is captured with the lo read so a lo-then-hi pair is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data   <= '0;
      time_hi_q <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
      if (rd_addr == ADDR_TIME_LO) time_hi_q <= time_in[63:32];
    end
  end

endmodule

// File: tb/tb_tc_timer_cmp.sv
// Self-checking bench for tc_timer_cmp: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_tc_timer_cmp;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic [63:0] time_in = '0;
  logic        wr_en   = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en   = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        irq_ack = 1'b0;
  logic [31:0] rd_data;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tc_timer_cmp dut (
    .clk     (clk),
    .rst     (rst),
    .time_in (time_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  localparam logic [1:0] DIS = 2'd0, ARM = 2'd1, PEN = 2'd2;

  typedef struct packed {
    logic [63:0] cmp;
    logic [31:0] shadow;
    logic [31:0] period;
    logic [31:0] thi;
    logic [31:0] rd;
    logic        en;
    logic        per;
    logic        missed;
    logic [1:0]  st;
  } mdl_t;

  localparam mdl_t MDL_RST = '{cmp: '1, shadow: '0, period: '0, thi: '0, rd: '0,
                               en: 1'b0, per: 1'b0, missed: 1'b0, st: DIS};

  mdl_t m = MDL_RST;

  // One clock edge of the timer, written from the register-level rules.
  function automatic mdl_t step(input mdl_t cur);
    mdl_t n;
    logic periodic, reached;
    n        = cur;
    periodic = cur.per && (cur.period != 32'd0);
    reached  = (time_in >= cur.cmp);
    if (wr_en && wr_addr == 3'd2) begin
      n.en     = wr_data[0];
      n.per    = wr_data[1];
      n.missed = 1'b0;
      if (!wr_data[0])      n.st = DIS;
      else if (cur.st == DIS) n.st = ARM;
    end else if (cur.st == ARM && reached) begin
      n.st = PEN;
      if (periodic) n.cmp = cur.cmp + 64'(cur.period);
    end else if (cur.st == PEN && irq_ack) begin
      if (periodic) n.st = ARM;
      else begin
        n.st = DIS;
        n.en = 1'b0;
      end
    end else if (cur.st == PEN && periodic && reached) begin
      n.missed = 1'b1;
      n.cmp    = cur.cmp + 64'(cur.period);
    end
    if (wr_en) begin
      case (wr_addr)
        3'd0:    n.shadow = wr_data;
        3'd1:    n.cmp    = {wr_data, cur.shadow};
        3'd3:    n.period = wr_data;
        default: ;
      endcase
    end
    if (rd_en) begin
      case (rd_addr)
        3'd0: n.rd = cur.cmp[31:0];
        3'd1: n.rd = cur.cmp[63:32];
        3'd2: n.rd = {27'd0, cur.st, cur.missed, cur.per, cur.en};
        3'd3: n.rd = cur.period;
        3'd4: begin
          n.rd  = time_in[31:0];
          n.thi = time_in[63:32];
        end
        3'd5:    n.rd = cur.thi;
        default: n.rd = 32'd0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= MDL_RST;
    else      m <= step(m);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_irq", irq, m.st == PEN);
    check("model_rd_data", rd_data, m.rd);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    check(name, rd_data, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic drive_random();
    wr_en   = ($urandom_range(0, 5) == 0);
    wr_addr = 3'($urandom_range(0, 7));
    case (wr_addr)
      3'd0:    wr_data = time_in[31:0] + $urandom_range(0, 40);
      3'd1:    wr_data = ($urandom_range(0, 7) == 0) ? $urandom() : time_in[63:32];
      3'd2:    wr_data = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 7));
      3'd3:    wr_data = 32'($urandom_range(0, 10));
      default: wr_data = $urandom();
    endcase
    rd_en   = $urandom_range(0, 1) == 1;
    rd_addr = 3'($urandom_range(0, 7));
    irq_ack = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 199) == 0) time_in = {32'($urandom_range(0, 1)), $urandom()};
    else                             time_in = time_in + 64'($urandom_range(0, 3));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("reset_irq", irq, 1'b0);
    rd_check("reset_cmp_lo", 3'd0, 32'hFFFF_FFFF);
    rd_check("reset_ctrl", 3'd2, 32'd0);

    // One-shot compare at 100.
    wr(3'd0, 32'd100); wr(3'd1, 32'd0); wr(3'd2, 32'd1);
    for (int t = 0; t <= 100; t++) begin
      time_in = 64'(t);
      @(negedge clk);
      if (t == 99) check("oneshot_before", irq, 1'b0);
    end
    check("oneshot_rise", irq, 1'b1);
    ack();
    check("oneshot_ack_irq", irq, 1'b0);
    rd_check("oneshot_ctrl", 3'd2, 32'd0);

    // Periodic: 50, then 70, cmp reads back 90.
    time_in = '0;
    wr(3'd0, 32'd50); wr(3'd1, 32'd0); wr(3'd3, 32'd20); wr(3'd2, 32'd3);
    for (int t = 0; t <= 50; t++) begin
      time_in = 64'(t);
      @(negedge clk);
    end
    check("periodic_first", irq, 1'b1);
    ack();
    check("periodic_ack", irq, 1'b0);
    for (int t = 51; t <= 70; t++) begin
      time_in = 64'(t);
      @(negedge clk);
      if (t == 69) check("periodic_gap", irq, 1'b0);
    end
    check("periodic_second", irq, 1'b1);
    rd_check("periodic_cmp_lo", 3'd0, 32'd90);
    ack();
    wr(3'd2, 32'd0);

    // Missed interrupt: cmp 10, period 5, no ack past 15.
    time_in = '0;
    wr(3'd0, 32'd10); wr(3'd1, 32'd0); wr(3'd3, 32'd5); wr(3'd2, 32'd3);
    for (int t = 0; t <= 16; t++) begin
      time_in = 64'(t);
      @(negedge clk);
    end
    rd_check("missed_status", 3'd2, 32'h17);
    rd_check("missed_cmp_lo", 3'd0, 32'd20);
    ack();
    wr(3'd2, 32'd0);

    // 64-bit wrap of the reload.
    time_in = '0;
    wr(3'd0, 32'hFFFF_FFF0); wr(3'd1, 32'hFFFF_FFFF); wr(3'd3, 32'h20); wr(3'd2, 32'd3);
    time_in = 64'hFFFF_FFFF_FFFF_FFF0;
    @(negedge clk);
    check("wrap_irq", irq, 1'b1);
    time_in = '0;
    rd_check("wrap_cmp_lo", 3'd0, 32'h10);
    rd_check("wrap_cmp_hi", 3'd1, 32'h0);
    ack();
    wr(3'd2, 32'd0);

    // Coherent lo-then-hi time read.
    time_in = 64'h1_FFFF_FFFF;
    rd_check("time_lo", 3'd4, 32'hFFFF_FFFF);
    time_in = 64'h2_0000_0000;
    rd_check("time_hi", 3'd5, 32'd1);

    // Asynchronous reset while pending.
    time_in = '0;
    wr(3'd0, 32'd5); wr(3'd1, 32'd0); wr(3'd2, 32'd1);
    time_in = 64'd5;
    @(negedge clk);
    check("prereset_irq", irq, 1'b1);
    #2 rst = 1'b0;
    #1 check("async_reset_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_irq", irq, 1'b0);
    rd_check("post_reset_ctrl", 3'd2, 32'd0);
    rd_check("post_reset_cmp_hi", 3'd1, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    time_in = '0;
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0; irq_ack = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc_timer_cmp.md
TC_TIMER_CMP -- requirements
Module: tc_timer_cmp

Interface
REQ-001 Parameter UUID SHALL have default 0 and identify the component instance.
REQ-002 Parameter NAME SHALL have default "" and hold the instance display name.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 time_in  in  64  SHALL be the free-running time value from the upstream timing source; unsigned.
REQ-006 wr_en  in  1  SHALL be the register write strobe, sampled on clk.
REQ-007 wr_addr  in  3  SHALL be the write address: 0 cmp_lo, 1 cmp_hi, 2 ctrl, 3 period.
REQ-008 wr_data  in  32  SHALL be the write data.
REQ-009 rd_en  in  1  SHALL be the read strobe.
REQ-010 rd_addr  in  3  SHALL be the read address: 0 cmp_lo, 1 cmp_hi, 2 ctrl/status, 3 period, 4 time_lo, 5 time_hi; 6-7 reserved.
REQ-011 rd_data  out  32  SHALL be the registered read data.
REQ-012 irq  out  1  SHALL be the timer interrupt, level, registered.
REQ-013 irq_ack  in  1  SHALL be the interrupt acknowledge, sampled on clk.

Function
REQ-014 State machine SHALL have states DISARMED, ARMED and PENDING.
REQ-015 A cmp_lo write SHALL load a 32-bit shadow only; cmp is unchanged.
REQ-016 A cmp_hi write SHALL commit cmp = {wr_data, shadow} atomically in one cycle.
REQ-017 ctrl SHALL decode as bit0 enable, bit1 periodic, bit2 missed (sticky, read-only); other bits SHALL read 0.
REQ-018 A ctrl write with enable=0 SHALL move any state to DISARMED and clear missed.
REQ-019 A ctrl write with enable=1 SHALL move DISARMED to ARMED, leave ARMED/PENDING unchanged, and clear missed.
REQ-020 In ARMED, time_in >= cmp (64-bit unsigned) SHALL move the state to PENDING on that edge.
REQ-021 irq SHALL be 1 exactly while the state is PENDING, giving 1-cycle latency from the match edge.
REQ-022 On entry to PENDING with periodic=1 and period!=0, cmp SHALL update to cmp + period modulo 2^64.
REQ-023 period=0 SHALL behave as one-shot.
REQ-024 irq_ack in PENDING SHALL move to ARMED if periodic (period!=0), else to DISARMED with enable cleared.
REQ-025 irq_ack outside PENDING SHALL be ignored.
REQ-026 In PENDING with periodic active, time_in >= the reloaded cmp SHALL set missed and reload cmp again.
REQ-027 A cmp_hi write and irq_ack on the same edge SHALL both take effect; the new cmp is used for the next compare.
REQ-028 If a ctrl write and irq_ack land on the same edge, the ctrl write SHALL win.
REQ-029 rd_data SHALL be valid the cycle after rd_en and hold until the next rd_en.
REQ-030 A time_lo read SHALL return time_in[31:0] and latch time_in[63:32] in the same cycle.
REQ-031 A time_hi read SHALL return that latched value, keeping a lo-then-hi pair coherent.
REQ-032 ctrl/status reads SHALL return {state[1:0] at bits 4:3, missed, periodic, enable}.
REQ-033 Reserved read addresses SHALL return 0; reserved write addresses SHALL be ignored.

Reset
REQ-034 On rst low, cmp SHALL be all-ones (never matches); shadow, period, ctrl, time_hi latch, rd_data and irq SHALL be 0; state SHALL be DISARMED.
REQ-035 Reset mid-PENDING SHALL drop irq asynchronously.
REQ-036 The first post-reset edge SHALL evaluate nothing pending.

Structure
REQ-037 Package tc_timer_pkg SHALL hold the state enum, register address constants and ctrl bit positions.
REQ-038 No sub-module is needed: registers, FSM and read mux SHALL live in tc_timer_cmp.

Verification
REQ-039 Write cmp_lo=100, cmp_hi=0, ctrl=1, then ramp time_in 0..120 -> irq rises the cycle after time_in=100; ack -> irq falls and ctrl enable=0.
REQ-040 Set cmp=50, period=20, ctrl=3, then ramp time_in -> irq at 50; ack; irq again at 70 with cmp readback 90.
REQ-041 Periodic with cmp=10, period=5; hold irq_ack=0 while time_in passes 15 -> missed=1 and cmp=20.
REQ-042 Set cmp=0xFFFFFFFF_FFFFFFF0, period=0x20, fire -> cmp wraps to 0x10.
REQ-043 Set time_in=0x1_FFFFFFFF, read time_lo, then change time_in to 0x2_00000000 and read time_hi -> returns 1.
REQ-044 Assert rst low while PENDING -> irq=0 immediately, state DISARMED, cmp=all-ones.
